// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - IF/ID-to-ID/EX control handshake bundle
// Ports: Opcode, Valid_in, Stall_in, Flush from the upstream side;
//        Ready_out, Valid_out, decoded control fields, LaneMask, Illegal,
//        Mul_busy, Bubble_cnt from the control unit.
interface pipe_control_unit_if #(
   parameter int LANES = 2,
   parameter int CNT_W = 16
);
   logic [5:0]       Opcode;
   logic             Valid_in;
   logic             Stall_in;
   logic             Flush;
   logic             Ready_out;
   logic             Valid_out;
   logic [1:0]       RegDst;
   logic             Jump;
   logic             Branch;
   logic             MemRead;
   logic             MemtoReg;
   logic             RegWrite;
   logic             ALUSrc;
   logic             D_addi;
   logic [2:0]       ALUOp;
   logic [LANES-1:0] LaneMask;
   logic             Illegal;
   logic             Mul_busy;
   logic [CNT_W-1:0] Bubble_cnt;

   modport master (
      output Opcode, Valid_in, Stall_in, Flush,
      input  Ready_out, Valid_out, RegDst, Jump, Branch, MemRead, MemtoReg,
             RegWrite, ALUSrc, D_addi, ALUOp, LaneMask, Illegal, Mul_busy,
             Bubble_cnt
   );

   modport slave (
      input  Opcode, Valid_in, Stall_in, Flush,
      output Ready_out, Valid_out, RegDst, Jump, Branch, MemRead, MemtoReg,
             RegWrite, ALUSrc, D_addi, ALUOp, LaneMask, Illegal, Mul_busy,
             Bubble_cnt
   );
endinterface

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - registered ID-stage main control with mul occupancy
// Ports: Clk, Rst_n (async, active low); bus (slave modport): opcode and
//        stall/flush in, registered ID/EX control word, lane mask, illegal
//        pulse, multiply-busy flag, saturating bubble counter out.
module pipe_control_unit #(
   parameter int LANES      = 2,
   parameter int MUL_CYCLES = 3,
   parameter int CNT_W      = 16
) (
   input  logic               Clk,
   input  logic               Rst_n,
   pipe_control_unit_if.slave bus
);
   localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef struct packed {
      logic [1:0]       reg_dst;
      logic             jump;
      logic             branch;
      logic             mem_read;
      logic             mem_to_reg;
      logic [2:0]       alu_op;
      logic             alu_src;
      logic             reg_write;
      logic             d_addi;
      logic [LANES-1:0] lane_mask;
   } ctrl_t;

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t            state_q, state_nx;
   logic [MC_W-1:0]   cnt_q, cnt_nx;
   ctrl_t             word_q, word_nx, dec;
   logic              valid_q, valid_nx;
   logic              illegal_q, illegal_nx;
   logic [CNT_W-1:0]  bcnt_q;
   logic              bump;
   logic              dec_legal, dec_mul;

   // Opcode decode; packed ops (Opcode[5:4]==11) override the scalar table.
   always_comb begin
      dec       = '0;
      dec_legal = 1'b1;
      dec_mul   = 1'b0;
      if (bus.Opcode[5:4] == 2'b11) begin
         dec.reg_dst   = 2'b01;
         dec.reg_write = 1'b1;
         dec.lane_mask = '1;
      end else begin
         dec.lane_mask = LANES'(1);
         case (bus.Opcode)
            6'b000000: begin dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
            6'b001000: begin dec.alu_op = 3'b010; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            6'b001110: begin
               dec.alu_op = 3'b010; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
               dec.d_addi = 1'b1;   dec.lane_mask = '1;
            end
            6'b001111: begin dec.reg_dst = 2'b01; dec.jump = 1'b1; dec.alu_op = 3'b111; dec.reg_write = 1'b1; end
            6'b011100: begin dec.reg_dst = 2'b01; dec.alu_op = 3'b001; dec.reg_write = 1'b1; dec_mul = 1'b1; end
            6'b100011: begin
               dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_op = 3'b011;
               dec.alu_src  = 1'b1; dec.reg_write  = 1'b1;
            end
            6'b000100: begin dec.reg_dst = 2'b01; dec.branch = 1'b1; dec.alu_op = 3'b100; end
            6'b000101: begin dec.reg_dst = 2'b01; dec.branch = 1'b1; dec.alu_op = 3'b101; end
            6'b000010: begin dec.reg_dst = 2'b01; dec.jump = 1'b1; dec.alu_op = 3'b111; end
            default: begin dec = '0; dec_legal = 1'b0; end
         endcase
      end
   end

   // State register plus all registered outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         bcnt_q    <= '0;
      end else begin
         state_q   <= state_nx;
         cnt_q     <= cnt_nx;
         word_q    <= word_nx;
         valid_q   <= valid_nx;
         illegal_q <= illegal_nx;
         if (bump && !(&bcnt_q))
            bcnt_q <= bcnt_q + 1'b1;
      end
   end

   // Next state: cnt_q counts the remaining mul cycles after the current one.
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      if (bus.Flush) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
      end else if (state_q == S_MUL) begin
         cnt_nx = cnt_q - 1'b1;
         if (cnt_q == MC_W'(1))
            state_nx = S_IDLE;
      end else if (bus.Valid_in && !bus.Stall_in && dec_mul && (MUL_CYCLES > 1)) begin
         state_nx = S_MUL;
         cnt_nx   = MC_W'(MUL_CYCLES - 1);
      end
   end

   // Next control word; while busy the mul word is held unchanged.
   always_comb begin
      word_nx    = word_q;
      valid_nx   = 1'b0;
      illegal_nx = 1'b0;
      bump       = 1'b0;
      if (bus.Flush) begin
         word_nx = '0;
         bump    = 1'b1;
      end else if (state_q == S_MUL) begin
         valid_nx = (cnt_q == MC_W'(1));
      end else if (bus.Stall_in || !bus.Valid_in) begin
         word_nx = '0;
         bump    = bus.Stall_in;
      end else if (dec_legal) begin
         word_nx  = dec;
         valid_nx = !(dec_mul && (MUL_CYCLES > 1));
      end else begin
         word_nx    = '0;
         illegal_nx = 1'b1;
      end
   end

   assign bus.Ready_out  = (state_q != S_MUL);
   assign bus.Mul_busy   = (state_q == S_MUL);
   assign bus.Valid_out  = valid_q;
   assign bus.Illegal    = illegal_q;
   assign bus.Bubble_cnt = bcnt_q;
   assign bus.RegDst     = word_q.reg_dst;
   assign bus.Jump       = word_q.jump;
   assign bus.Branch     = word_q.branch;
   assign bus.MemRead    = word_q.mem_read;
   assign bus.MemtoReg   = word_q.mem_to_reg;
   assign bus.ALUOp      = word_q.alu_op;
   assign bus.ALUSrc     = word_q.alu_src;
   assign bus.RegWrite   = word_q.reg_write;
   assign bus.D_addi     = word_q.d_addi;
   assign bus.LaneMask   = word_q.lane_mask;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed self-checking bench for pipe_control_unit
module tb_pipe_control_unit;
   logic Clk = 1'b0;
   logic Rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_bc = 0;

   pipe_control_unit_if #(.LANES(4), .CNT_W(4)) bus ();

   pipe_control_unit #(.LANES(4), .MUL_CYCLES(3), .CNT_W(4)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, ALUSrc, RegWrite, D_addi}
   wire [11:0] ctl = {bus.RegDst, bus.Jump, bus.Branch, bus.MemRead, bus.MemtoReg,
                      bus.ALUOp, bus.ALUSrc, bus.RegWrite, bus.D_addi};
   // {ctl, LaneMask, Valid_out, Illegal, Mul_busy, Ready_out}
   wire [19:0] obs = {ctl, bus.LaneMask, bus.Valid_out, bus.Illegal, bus.Mul_busy, bus.Ready_out};

   localparam logic [11:0] W_R     = 12'b01_0_0_0_0_000_0_1_0;
   localparam logic [11:0] W_ADDI  = 12'b00_0_0_0_0_010_1_1_0;
   localparam logic [11:0] W_DADDI = 12'b00_0_0_0_0_010_1_1_1;
   localparam logic [11:0] W_ADDJ  = 12'b01_1_0_0_0_111_0_1_0;
   localparam logic [11:0] W_MUL   = 12'b01_0_0_0_0_001_0_1_0;
   localparam logic [11:0] W_LW    = 12'b00_0_0_1_1_011_1_1_0;
   localparam logic [11:0] W_BEQ   = 12'b01_0_1_0_0_100_0_0_0;
   localparam logic [11:0] W_BNE   = 12'b01_0_1_0_0_101_0_0_0;
   localparam logic [11:0] W_J     = 12'b01_1_0_0_0_111_0_0_0;
   localparam logic [19:0] IDLE    = {12'h000, 4'b0000, 4'b0001};

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset;
      Rst_n = 1'b0;
      bus.Opcode = 6'b000000; bus.Valid_in = 1'b0; bus.Stall_in = 1'b0; bus.Flush = 1'b0;
      tick(); tick();
      Rst_n = 1'b1;
      tick(); tick();
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL reset_obs: got %h want %h", obs, IDLE); end
      n_cmp++;
      if (bus.Bubble_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_bcnt: got %0d want 0", bus.Bubble_cnt); end
   endtask

   task automatic test_decode;
      logic [5:0]  ops [9] = '{6'b000000, 6'b001000, 6'b001110, 6'b001111, 6'b100011,
                               6'b000100, 6'b000101, 6'b000010, 6'b110000};
      logic [15:0] exp [9] = '{{W_R, 4'b0001}, {W_ADDI, 4'b0001}, {W_DADDI, 4'b1111},
                               {W_ADDJ, 4'b0001}, {W_LW, 4'b0001}, {W_BEQ, 4'b0001},
                               {W_BNE, 4'b0001}, {W_J, 4'b0001}, {W_R, 4'b1111}};
      logic [19:0] want;
      for (int i = 0; i < 9; i++) begin
         bus.Opcode = ops[i]; bus.Valid_in = 1'b1;
         tick();
         want = {exp[i], 4'b1001};
         n_cmp++;
         if (obs !== want) begin n_bad++; $display("FAIL decode_%b: got %h want %h", ops[i], obs, want); end
      end
      bus.Valid_in = 1'b0;
      tick();
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL decode_idle: got %h want %h", obs, IDLE); end
      n_cmp++;
      if (bus.Bubble_cnt !== 4'(exp_bc)) begin n_bad++; $display("FAIL decode_bcnt: got %0d want %0d", bus.Bubble_cnt, exp_bc); end
   endtask

   task automatic test_multiply;
      logic [19:0] want [4] = '{{W_MUL, 4'b0001, 4'b0010}, {W_MUL, 4'b0001, 4'b0010},
                                {W_MUL, 4'b0001, 4'b1001}, {W_ADDI, 4'b0001, 4'b1001}};
      bus.Opcode = 6'b011100; bus.Valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.Opcode = 6'b001000;
         n_cmp++;
         if (obs !== want[i]) begin n_bad++; $display("FAIL mul_cycle%0d: got %h want %h", i, obs, want[i]); end
      end
      bus.Valid_in = 1'b0;
      tick();
   endtask

   task automatic test_flush_mul;
      bus.Opcode = 6'b011100; bus.Valid_in = 1'b1;
      tick();
      bus.Flush = 1'b1; bus.Opcode = 6'b001000;
      tick();
      bus.Flush = 1'b0; bus.Valid_in = 1'b0;
      exp_bc++;
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL flush_mid_mul: got %h want %h", obs, IDLE); end
      n_cmp++;
      if (bus.Bubble_cnt !== 4'(exp_bc)) begin n_bad++; $display("FAIL flush_mid_bcnt: got %0d want %0d", bus.Bubble_cnt, exp_bc); end
      // Flush on the final multiply cycle kills the result.
      bus.Opcode = 6'b011100; bus.Valid_in = 1'b1;
      tick();
      bus.Valid_in = 1'b0;
      tick();
      bus.Flush = 1'b1;
      tick();
      bus.Flush = 1'b0;
      exp_bc++;
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL flush_last_mul: got %h want %h", obs, IDLE); end
      n_cmp++;
      if (bus.Bubble_cnt !== 4'(exp_bc)) begin n_bad++; $display("FAIL flush_last_bcnt: got %0d want %0d", bus.Bubble_cnt, exp_bc); end
   endtask

   task automatic test_flush_stall;
      bus.Opcode = 6'b001000; bus.Valid_in = 1'b1; bus.Stall_in = 1'b1; bus.Flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_bc++;
         n_cmp++;
         if (obs !== IDLE) begin n_bad++; $display("FAIL flush_stall_obs%0d: got %h want %h", i, obs, IDLE); end
         n_cmp++;
         if (bus.Bubble_cnt !== 4'(exp_bc)) begin n_bad++; $display("FAIL flush_stall_bcnt%0d: got %0d want %0d", i, bus.Bubble_cnt, exp_bc); end
      end
      bus.Flush = 1'b0;
   endtask

   task automatic test_stall_sat;
      bus.Stall_in = 1'b1; bus.Valid_in = 1'b1; bus.Opcode = 6'b000000;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (exp_bc < 15) exp_bc++;
         n_cmp++;
         if (obs !== IDLE) begin n_bad++; $display("FAIL stall_obs%0d: got %h want %h", i, obs, IDLE); end
         n_cmp++;
         if (bus.Bubble_cnt !== 4'(exp_bc)) begin n_bad++; $display("FAIL stall_bcnt%0d: got %0d want %0d", i, bus.Bubble_cnt, exp_bc); end
      end
      bus.Stall_in = 1'b0; bus.Valid_in = 1'b0;
      tick();
      n_cmp++;
      if (bus.Bubble_cnt !== 4'd15) begin n_bad++; $display("FAIL stall_saturated: got %0d want 15", bus.Bubble_cnt); end
   endtask

   task automatic test_illegal;
      logic [19:0] want_pk = {W_R, 4'b1111, 4'b1001};
      logic [19:0] want_il = {12'h000, 4'b0000, 4'b0101};
      bus.Opcode = 6'b111111; bus.Valid_in = 1'b1;
      tick();
      n_cmp++;
      if (obs !== want_pk) begin n_bad++; $display("FAIL packed_111111: got %h want %h", obs, want_pk); end
      bus.Opcode = 6'b010011;
      tick();
      bus.Valid_in = 1'b0;
      n_cmp++;
      if (obs !== want_il) begin n_bad++; $display("FAIL illegal_pulse: got %h want %h", obs, want_il); end
      tick();
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL illegal_clear: got %h want %h", obs, IDLE); end
   endtask

   task automatic test_async_reset;
      bus.Opcode = 6'b011100; bus.Valid_in = 1'b1;
      tick();
      bus.Valid_in = 1'b0;
      n_cmp++;
      if (bus.Mul_busy !== 1'b1) begin n_bad++; $display("FAIL async_pre_busy: got %b want 1", bus.Mul_busy); end
      #2 Rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL async_reset_obs: got %h want %h", obs, IDLE); end
      n_cmp++;
      if (bus.Bubble_cnt !== 4'd0) begin n_bad++; $display("FAIL async_reset_bcnt: got %0d want 0", bus.Bubble_cnt); end
      Rst_n = 1'b1;
      tick();
      n_cmp++;
      if (obs !== IDLE) begin n_bad++; $display("FAIL post_reset_obs: got %h want %h", obs, IDLE); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_multiply();
      test_flush_mul();
      test_flush_stall();
      test_stall_sat();
      test_illegal();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Registered, parametrised main-control stage for the pipelined MIPS datapath. Decodes the 6-bit opcode held in IF/ID and writes the resulting control bundle into the ID/EX control register. Also handles stall and flush bubbles, multi-cycle multiply occupancy, and per-lane enables for packed (SIMD) operations. It replaces the purely combinational decoder at the ID stage and feeds EX/MEM/WB control directly.

## Interface
Parameters:
- LANES, 2, number of packed-datapath lanes; ≥1; sets LaneMask width
- MUL_CYCLES, 3, EX occupancy of mul in cycles; ≥1
- CNT_W, 16, width of the saturating bubble counter

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction[31:26] from IF/ID
- Valid_in  in  1  IF/ID holds a real instruction
- Stall_in  in  1  load-use stall from hazard unit
- Flush  in  1  branch/jump taken; kill the instruction in ID
- Ready_out  out  1  combinational; = !Mul_busy
- Valid_out  out  1  registered; the ID/EX control word is live
- RegDst  out  2  registered
- Jump, Branch, MemRead, MemtoReg, RegWrite, ALUSrc, D_addi  out  1 each  registered
- ALUOp  out  3  registered
- LaneMask  out  LANES  registered; per-lane write enable
- Illegal  out  1  registered; one-cycle pulse on an undefined opcode
- Mul_busy  out  1  registered; multiply occupying EX
- Bubble_cnt  out  CNT_W  saturating count of bubbles inserted

## Operation
Decode fields are {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, ALUSrc, RegWrite, D_addi}. Values not listed are 0.
- 000000 R-type: 01,0,0,0,0,000,0,1,0
- 001000 addi: 00,0,0,0,0,010,1,1,0
- 001110 daddi: as addi with D_addi=1; LaneMask all ones
- 001111 addj: 01,1,0,0,0,111,0,1,0
- 011100 mul: 01,0,0,0,0,001,0,1,0
- 100011 lw: 00,0,0,1,1,011,1,1,0
- 000100 beq: 01,0,1,0,0,100,0,0,0
- 000101 bne: 01,0,1,0,0,101,0,0,0
- 000010 j: 01,1,0,0,0,111,0,0,0
- Opcode[5:4]=11 (packed R-type): R-type word, LaneMask all ones; this takes priority over the table.
- Every other scalar opcode: LaneMask = 1 (lane 0 only).
- Any other opcode: bubble word with Illegal=1 and Valid_out=0.

Bubble word: all control fields 0, LaneMask 0, Valid_out 0.

Per-edge priority, highest first:
1. Flush: load a bubble, clear the multiply counter and Mul_busy, increment Bubble_cnt.
2. Mul_busy: hold the mul control word, decrement the counter, drive Valid_out=1 only on the cycle where the counter reaches 0.
3. Stall_in or !Valid_in: load a bubble. Increment Bubble_cnt only for Stall_in.
4. Accept: load the decoded word with Valid_out=1. For mul with MUL_CYCLES>1, load the counter with MUL_CYCLES-1, set Mul_busy, and drive Valid_out=0 until the final cycle.

Bubble_cnt saturates at all ones and never wraps.

## Timing
- Reset (asynchronous, any cycle including mid-multiply): every registered output is 0, the counter is 0, and Ready_out=1.
- Decode latency: 1 cycle. Opcode sampled at edge N appears on the outputs after edge N.
- A mul occupies the output register for exactly MUL_CYCLES cycles. Ready_out is low for the first MUL_CYCLES-1 of those cycles. An upstream instruction presented while Ready_out=0 is not consumed and must be held by IF/ID.
- MUL_CYCLES=1: mul behaves like any single-cycle op; Mul_busy never asserts.
- Simultaneous Flush and Stall_in: Flush wins; Bubble_cnt increments once.
- Simultaneous Flush and the last multiply cycle: the multiply is killed and Valid_out stays 0.
- Illegal is high for exactly one cycle per accepted illegal opcode and is 0 during bubbles.

## Test plan
- Reset, then hold: release Rst_n with Valid_in=0 -> all outputs 0, Ready_out=1, Bubble_cnt=0.
- Decode sweep: one opcode per cycle over every table entry -> each word matches the table one cycle later with Valid_out=1; for LANES=4, opcode 110000 gives LaneMask=1111 and addi gives 0001.
- Multiply occupancy: MUL_CYCLES=3, mul followed by addi -> Mul_busy=1 for 2 cycles, Ready_out=0 for 2 cycles, Valid_out=1 on the third cycle only, addi output on the fourth cycle.
- Flush mid-multiply: Flush one cycle after a mul is accepted -> bubble next cycle, Mul_busy=0, Ready_out=1, Bubble_cnt+1.
- Stall and saturation: CNT_W=4 with Stall_in high for 20 cycles -> bubbles throughout and Bubble_cnt stops at 15; with Stall_in and Flush both high, Bubble_cnt increments once per cycle.
- Illegal and async reset: opcode 111111 is packed and therefore legal; opcode 010011 -> Illegal pulses for one cycle. Asserting Rst_n low mid-multiply clears all outputs immediately, without waiting for a clock edge.
